lcd_access_sched: RTL

//  Owns the VC707 16x2 character LCD (HD44780-compatible, 4-bit bus, write-only).
//  - After reset, runs the power-on init sequence.
//  - Then round-robin arbitrates two byte requesters (e.g. text writer, command source).
//  - Sequences each granted byte as two timed nibble writes plus the command-execution wait.

---
 rtl/lcd_pkg.sv | 56 +++++
 rtl/lcd_nibble_writer.sv | 93 +++++++++
 rtl/lcd_access_sched.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared types, init ROM and helpers for the HD44780 LCD access scheduler.
package lcd_pkg;

    localparam int unsigned CNT_W      = 22;
    localparam int unsigned INIT_STEPS = 8;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_NIB_HI,
        ST_GAP,
        ST_NIB_LO,
        ST_CMD_WAIT
    } state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_SETUP,
        W_E_HIGH,
        W_HOLD
    } wr_state_e;

    typedef enum logic [1:0] {
        WAIT_SHORT,
        WAIT_LONG,
        WAIT_INIT
    } wait_sel_e;

    typedef struct packed {
        logic      is_nibble;
        logic      rs;
        logic [7:0] value;
        wait_sel_e wait_sel;
    } init_step_t;

    // Power-on init steps: four lone nibbles, then four full command bytes.
    function automatic init_step_t init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{1'b1, 1'b0, 8'h03, WAIT_INIT};
            3'd1:    return '{1'b1, 1'b0, 8'h03, WAIT_SHORT};
            3'd2:    return '{1'b1, 1'b0, 8'h03, WAIT_SHORT};
            3'd3:    return '{1'b1, 1'b0, 8'h02, WAIT_SHORT};
            3'd4:    return '{1'b0, 1'b0, 8'h28, WAIT_SHORT};
            3'd5:    return '{1'b0, 1'b0, 8'h0C, WAIT_SHORT};
            3'd6:    return '{1'b0, 1'b0, 8'h01, WAIT_LONG};
            default: return '{1'b0, 1'b0, 8'h06, WAIT_SHORT};
        endcase
    endfunction

    // Clear display / return home need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one nibble onto the LCD bus with setup, E pulse and hold timing.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 8,
    parameter int unsigned E_CYC     = 48,
    parameter int unsigned HOLD_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] nib,
    input  logic       rs,
    output logic       done_c,
    output logic       lcd_e,
    output logic [3:0] lcd_data,
    output logic       lcd_rs
);

    wr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic [3:0]       data_q, data_d;
    logic             rs_q, rs_d;

    // Next-state: data/RS only change when E is low; done_c marks the last hold cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_d     = e_q;
        data_d  = data_q;
        rs_d    = rs_q;
        done_c  = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (start) begin
                    data_d  = nib;
                    rs_d    = rs;
                    cnt_d   = CNT_W'(SETUP_CYC - 1);
                    state_d = W_SETUP;
                end
            end
            W_SETUP: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b1;
                    cnt_d   = CNT_W'(E_CYC - 1);
                    state_d = W_E_HIGH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            W_E_HIGH: begin
                if (cnt_q == '0) begin
                    e_d     = 1'b0;
                    cnt_d   = CNT_W'(HOLD_CYC - 1);
                    state_d = W_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    done_c  = 1'b1;
                    state_d = W_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    // State and bus registers; reset drops E immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            data_q  <= 4'h0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

    assign lcd_e    = e_q;
    assign lcd_data = data_q;
    assign lcd_rs   = rs_q;

endmodule

// File: rtl/lcd_access_sched.sv
// LCD owner: power-on init, round-robin arbitration of two byte sources, byte/wait sequencing.
module lcd_access_sched
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC      = 8,
    parameter int unsigned E_CYC          = 48,
    parameter int unsigned HOLD_CYC       = 4,
    parameter int unsigned NIB_GAP_CYC    = 200,
    parameter int unsigned WAIT_SHORT_CYC = 8000,
    parameter int unsigned WAIT_LONG_CYC  = 328000,
    parameter int unsigned INIT_WAIT_CYC  = 820000,
    parameter int unsigned PWR_WAIT_CYC   = 3000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_rs,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic        grant_id,
    output logic        init_done,
    output logic        busy,
    output logic [3:0]  lcd_data,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;
    logic             init_done_q, init_done_d;
    logic             busy_q, busy_d;
    logic             grant_q, grant_d;
    logic             rr_last_q, rr_last_d;
    logic [7:0]       cur_data_q, cur_data_d;
    logic             cur_rs_q, cur_rs_d;
    logic             cur_nib_only_q, cur_nib_only_d;
    wait_sel_e        cur_wait_q, cur_wait_d;

    logic             wr_start_c;
    logic [3:0]       wr_nib_c;
    logic             wr_rs_c;
    logic             wr_done_c;
    logic             g_c;
    logic [7:0]       sel_byte_c;
    logic             sel_rs_c;
    init_step_t       rom_step_c;

    // Reload value for the post-write execution wait.
    function automatic logic [CNT_W-1:0] wait_load(input wait_sel_e sel);
        case (sel)
            WAIT_LONG: return CNT_W'(WAIT_LONG_CYC - 1);
            WAIT_INIT: return CNT_W'(INIT_WAIT_CYC - 1);
            default:   return CNT_W'(WAIT_SHORT_CYC - 1);
        endcase
    endfunction

    // Sequencer, arbiter and nibble launch; ready is a same-cycle accept strobe in IDLE.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        step_d         = step_q;
        init_done_d    = init_done_q;
        grant_d        = grant_q;
        rr_last_d      = rr_last_q;
        cur_data_d     = cur_data_q;
        cur_rs_d       = cur_rs_q;
        cur_nib_only_d = cur_nib_only_q;
        cur_wait_d     = cur_wait_q;
        req_ready      = 2'b00;
        wr_start_c     = 1'b0;
        wr_nib_c       = cur_data_q[7:4];
        wr_rs_c        = cur_rs_q;
        rom_step_c     = init_rom(step_q);
        g_c            = (&req_valid) ? ~rr_last_q : req_valid[1];
        sel_byte_c     = g_c ? req_data[15:8] : req_data[7:0];
        sel_rs_c       = g_c ? req_rs[1] : req_rs[0];
        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_q == '0) state_d = ST_INIT;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_INIT: begin
                wr_start_c     = 1'b1;
                wr_nib_c       = rom_step_c.is_nibble ? rom_step_c.value[3:0]
                                                      : rom_step_c.value[7:4];
                wr_rs_c        = rom_step_c.rs;
                cur_data_d     = rom_step_c.value;
                cur_rs_d       = rom_step_c.rs;
                cur_nib_only_d = rom_step_c.is_nibble;
                cur_wait_d     = rom_step_c.wait_sel;
                state_d        = ST_NIB_HI;
            end
            ST_IDLE: begin
                if (|req_valid) begin
                    req_ready      = g_c ? 2'b10 : 2'b01;
                    grant_d        = g_c;
                    rr_last_d      = g_c;
                    cur_data_d     = sel_byte_c;
                    cur_rs_d       = sel_rs_c;
                    cur_nib_only_d = 1'b0;
                    cur_wait_d     = is_long_cmd(sel_rs_c, sel_byte_c) ? WAIT_LONG : WAIT_SHORT;
                    wr_start_c     = 1'b1;
                    wr_nib_c       = sel_byte_c[7:4];
                    wr_rs_c        = sel_rs_c;
                    state_d        = ST_NIB_HI;
                end
            end
            ST_NIB_HI: begin
                if (wr_done_c) begin
                    if (cur_nib_only_q) begin
                        cnt_d   = wait_load(cur_wait_q);
                        state_d = ST_CMD_WAIT;
                    end else begin
                        cnt_d   = CNT_W'(NIB_GAP_CYC - 1);
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    wr_start_c = 1'b1;
                    wr_nib_c   = cur_data_q[3:0];
                    state_d    = ST_NIB_LO;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_NIB_LO: begin
                if (wr_done_c) begin
                    cnt_d   = wait_load(cur_wait_q);
                    state_d = ST_CMD_WAIT;
                end
            end
            ST_CMD_WAIT: begin
                if (cnt_q == '0) begin
                    if (init_done_q) begin
                        state_d = ST_IDLE;
                    end else if (step_q == 3'(INIT_STEPS - 1)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = ST_INIT;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_PWR_WAIT;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control registers; reset restarts the full power-on sequence with req0 favoured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_PWR_WAIT;
            cnt_q          <= CNT_W'(PWR_WAIT_CYC - 1);
            step_q         <= 3'd0;
            init_done_q    <= 1'b0;
            busy_q         <= 1'b1;
            grant_q        <= 1'b0;
            rr_last_q      <= 1'b1;
            cur_data_q     <= 8'h00;
            cur_rs_q       <= 1'b0;
            cur_nib_only_q <= 1'b0;
            cur_wait_q     <= WAIT_SHORT;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            step_q         <= step_d;
            init_done_q    <= init_done_d;
            busy_q         <= busy_d;
            grant_q        <= grant_d;
            rr_last_q      <= rr_last_d;
            cur_data_q     <= cur_data_d;
            cur_rs_q       <= cur_rs_d;
            cur_nib_only_q <= cur_nib_only_d;
            cur_wait_q     <= cur_wait_d;
        end
    end

    lcd_nibble_writer #(
        .SETUP_CYC (SETUP_CYC),
        .E_CYC     (E_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start_c),
        .nib      (wr_nib_c),
        .rs       (wr_rs_c),
        .done_c   (wr_done_c),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .lcd_rs   (lcd_rs)
    );

    assign grant_id  = grant_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign lcd_rw    = 1'b0;

endmodule
